// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 microcoded control unit: COND codes,
// named microstates and the packed microinstruction layout.
package lc3_ctrl_pkg;

  localparam logic [2:0] COND_NONE  = 3'b000;
  localparam logic [2:0] COND_R     = 3'b001;
  localparam logic [2:0] COND_BEN   = 3'b010;
  localparam logic [2:0] COND_PSR15 = 3'b011;
  localparam logic [2:0] COND_IR11  = 3'b100;
  localparam logic [2:0] COND_INT   = 3'b101;
  localparam logic [2:0] COND_ACV   = 3'b110;

  localparam logic [5:0] ST_BR     = 6'd0;
  localparam logic [5:0] ST_ADD    = 6'd1;
  localparam logic [5:0] ST_FETCH  = 6'd18;
  localparam logic [5:0] ST_BR_TKN = 6'd22;
  localparam logic [5:0] ST_READ   = 6'd28;
  localparam logic [5:0] ST_LDIR   = 6'd30;
  localparam logic [5:0] ST_DECODE = 6'd32;
  localparam logic [5:0] ST_ACV    = 6'd33;
  localparam logic [5:0] ST_VECTOR = 6'd52;

  // Load enables, MSB first: {MAR, MDR, IR, BEN, REG, CC, PC, Priv, SavedSSP, SavedUSP, Vector}
  localparam int unsigned LD_W = 11;
  localparam logic [LD_W-1:0] LD_MAR    = 11'h400;
  localparam logic [LD_W-1:0] LD_MDR    = 11'h200;
  localparam logic [LD_W-1:0] LD_IR     = 11'h100;
  localparam logic [LD_W-1:0] LD_BEN    = 11'h080;
  localparam logic [LD_W-1:0] LD_REG    = 11'h040;
  localparam logic [LD_W-1:0] LD_CC     = 11'h020;
  localparam logic [LD_W-1:0] LD_PC     = 11'h010;
  localparam logic [LD_W-1:0] LD_PRIV   = 11'h008;
  localparam logic [LD_W-1:0] LD_SSP    = 11'h004;
  localparam logic [LD_W-1:0] LD_USP    = 11'h002;
  localparam logic [LD_W-1:0] LD_VECTOR = 11'h001;

  // Gate enables, MSB first: {PC, MDR, ALU, MARMUX, Vector, PCm1, PSR, SP}
  localparam int unsigned GATE_W = 8;
  localparam logic [GATE_W-1:0] G_PC     = 8'h80;
  localparam logic [GATE_W-1:0] G_MDR    = 8'h40;
  localparam logic [GATE_W-1:0] G_ALU    = 8'h20;
  localparam logic [GATE_W-1:0] G_MARMUX = 8'h10;
  localparam logic [GATE_W-1:0] G_VECTOR = 8'h08;
  localparam logic [GATE_W-1:0] G_PCM1   = 8'h04;
  localparam logic [GATE_W-1:0] G_PSR    = 8'h02;
  localparam logic [GATE_W-1:0] G_SP     = 8'h01;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  // Field order fixes the bit positions, j occupying the MSBs.
  typedef struct packed {
    logic [5:0]        j;
    logic [2:0]        cond;
    logic              ird;
    logic [LD_W-1:0]   ld;
    logic [GATE_W-1:0] gate;
    logic [1:0]        pcmux;
    logic [1:0]        drmux;
    logic [1:0]        sr1mux;
    logic [1:0]        addr2mux;
    logic [1:0]        spmux;
    logic [1:0]        vectormux;
    logic [1:0]        aluk;
    logic              addr1mux;
    logic              marmux;
    logic              tablemux;
    logic              psrmux;
    logic              mio_en;
    logic              r_w;
    logic              set_priv;
  } ctrl_word_t;

  localparam int unsigned CW_W = $bits(ctrl_word_t);

endpackage

// File: rtl/lc3_control_rom.sv
// Microcode ROM: maps a microstate to its control word. States with no
// microinstruction fall back to fetch with every enable cleared.
module lc3_control_rom
  import lc3_ctrl_pkg::*;
(
  input  logic [5:0] state,
  output ctrl_word_t cw,
  output logic       illegal
);

  always_comb begin
    cw      = '0;
    illegal = 1'b0;
    case (state)
      6'd0:  begin cw.cond = COND_BEN; cw.j = ST_FETCH; end
      6'd1:  begin cw.ld = LD_REG | LD_CC; cw.gate = G_ALU; cw.aluk = ALUK_ADD; cw.sr1mux = 2'b01; cw.j = ST_FETCH; end
      6'd5:  begin cw.ld = LD_REG | LD_CC; cw.gate = G_ALU; cw.aluk = ALUK_AND; cw.sr1mux = 2'b01; cw.j = ST_FETCH; end
      6'd9:  begin cw.ld = LD_REG | LD_CC; cw.gate = G_ALU; cw.aluk = ALUK_NOT; cw.sr1mux = 2'b01; cw.j = ST_FETCH; end
      6'd2:  begin cw.ld = LD_MAR; cw.gate = G_MARMUX; cw.marmux = 1'b1; cw.addr2mux = 2'b10; cw.j = 6'd25; end
      6'd3:  begin cw.ld = LD_MAR; cw.gate = G_MARMUX; cw.marmux = 1'b1; cw.addr2mux = 2'b10; cw.j = 6'd23; end
      6'd10: begin cw.ld = LD_MAR; cw.gate = G_MARMUX; cw.marmux = 1'b1; cw.addr2mux = 2'b10; cw.j = 6'd24; end
      6'd11: begin cw.ld = LD_MAR; cw.gate = G_MARMUX; cw.marmux = 1'b1; cw.addr2mux = 2'b10; cw.j = 6'd29; end
      6'd6:  begin cw.ld = LD_MAR; cw.gate = G_MARMUX; cw.marmux = 1'b1; cw.addr1mux = 1'b1;
                   cw.addr2mux = 2'b01; cw.sr1mux = 2'b01; cw.j = 6'd25; end
      6'd7:  begin cw.ld = LD_MAR; cw.gate = G_MARMUX; cw.marmux = 1'b1; cw.addr1mux = 1'b1;
                   cw.addr2mux = 2'b01; cw.sr1mux = 2'b01; cw.j = 6'd23; end
      6'd4:  begin cw.ld = LD_REG; cw.gate = G_PC; cw.drmux = 2'b01; cw.cond = COND_IR11; cw.j = 6'd20; end
      6'd12, 6'd20:
             begin cw.ld = LD_PC; cw.pcmux = 2'b10; cw.addr1mux = 1'b1; cw.sr1mux = 2'b01; cw.j = ST_FETCH; end
      6'd21: begin cw.ld = LD_PC; cw.pcmux = 2'b10; cw.addr2mux = 2'b11; cw.j = ST_FETCH; end
      6'd22: begin cw.ld = LD_PC; cw.pcmux = 2'b10; cw.addr2mux = 2'b10; cw.j = ST_FETCH; end
      6'd14: begin cw.ld = LD_REG; cw.gate = G_MARMUX; cw.marmux = 1'b1; cw.addr2mux = 2'b10; cw.j = ST_FETCH; end
      // TRAP: vector table lookup, save return address in R7, jump.
      6'd15: begin cw.ld = LD_MAR; cw.gate = G_MARMUX; cw.j = 6'd40; end
      6'd40: begin cw.ld = LD_MDR; cw.mio_en = 1'b1; cw.cond = COND_R; cw.j = 6'd40; end
      6'd42: begin cw.ld = LD_REG; cw.gate = G_PC; cw.drmux = 2'b01; cw.j = 6'd34; end
      6'd34: begin cw.ld = LD_PC; cw.gate = G_MDR; cw.pcmux = 2'b01; cw.j = ST_FETCH; end
      6'd23: begin cw.ld = LD_MDR; cw.gate = G_ALU; cw.aluk = ALUK_PASSA; cw.j = 6'd16; end
      6'd16: begin cw.mio_en = 1'b1; cw.r_w = 1'b1; cw.cond = COND_R; cw.j = 6'd16; end
      6'd24: begin cw.ld = LD_MDR; cw.mio_en = 1'b1; cw.cond = COND_R; cw.j = 6'd24; end
      6'd26: begin cw.ld = LD_MAR; cw.gate = G_MDR; cw.j = 6'd25; end
      6'd25: begin cw.ld = LD_MDR; cw.mio_en = 1'b1; cw.cond = COND_R; cw.j = 6'd25; end
      6'd27: begin cw.ld = LD_REG | LD_CC; cw.gate = G_MDR; cw.j = ST_FETCH; end
      6'd29: begin cw.ld = LD_MDR; cw.mio_en = 1'b1; cw.cond = COND_R; cw.j = 6'd29; end
      6'd31: begin cw.ld = LD_MAR; cw.gate = G_MDR; cw.j = 6'd23; end
      6'd18: begin cw.ld = LD_MAR | LD_PC; cw.gate = G_PC; cw.cond = COND_INT; cw.j = ST_ACV; end
      6'd33: begin cw.cond = COND_ACV; cw.j = ST_READ; end
      6'd28: begin cw.ld = LD_MDR; cw.mio_en = 1'b1; cw.cond = COND_R; cw.j = ST_READ; end
      6'd30: begin cw.ld = LD_IR; cw.gate = G_MDR; cw.j = ST_DECODE; end
      6'd32: begin cw.ld = LD_BEN; cw.ird = 1'b1; end
      // RTI: pop PC from the supervisor stack; user mode takes the privilege exception.
      6'd8:  begin cw.ld = LD_MAR; cw.gate = G_ALU; cw.aluk = ALUK_PASSA; cw.sr1mux = 2'b10;
                   cw.cond = COND_PSR15; cw.j = 6'd36; end
      6'd36: begin cw.ld = LD_MDR; cw.mio_en = 1'b1; cw.cond = COND_R; cw.j = 6'd36; end
      6'd38: begin cw.ld = LD_PC; cw.gate = G_MDR; cw.pcmux = 2'b01; cw.j = 6'd39; end
      6'd39: begin cw.ld = LD_REG; cw.gate = G_SP; cw.sr1mux = 2'b10; cw.drmux = 2'b10; cw.j = ST_FETCH; end
      6'd13: begin cw.ld = LD_VECTOR; cw.tablemux = 1'b1; cw.vectormux = 2'b01; cw.j = ST_VECTOR; end
      6'd44: begin cw.ld = LD_VECTOR; cw.tablemux = 1'b1; cw.j = ST_VECTOR; end
      6'd60: begin cw.ld = LD_VECTOR | LD_PRIV; cw.tablemux = 1'b1; cw.vectormux = 2'b10; cw.j = ST_VECTOR; end
      6'd49: begin cw.ld = LD_VECTOR | LD_MDR | LD_PRIV; cw.gate = G_PSR; cw.psrmux = 1'b1; cw.j = ST_VECTOR; end
      6'd52: begin cw.ld = LD_MAR; cw.gate = G_VECTOR; cw.j = 6'd53; end
      6'd53: begin cw.ld = LD_MDR; cw.mio_en = 1'b1; cw.cond = COND_R; cw.j = 6'd53; end
      6'd55: begin cw.ld = LD_PC; cw.gate = G_MDR; cw.pcmux = 2'b01; cw.j = ST_FETCH; end
      default: begin
        cw.j    = ST_FETCH;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lc3_control_store.sv
// Microstate register plus control-word decode. All outputs are Moore:
// they depend only on the registered state.
module lc3_control_store
  import lc3_ctrl_pkg::*;
#(
  parameter logic [5:0] RESET_STATE = ST_FETCH
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [5:0]  i_AddressNextState,
  input  logic        i_Run,
  output logic [5:0]  o_State,
  output logic [5:0]  o_j_field,
  output logic [2:0]  o_COND_bits,
  output logic        o_IRD,
  output logic [10:0] o_LD,
  output logic [7:0]  o_Gate,
  output logic [1:0]  o_PCMUX,
  output logic [1:0]  o_DRMUX,
  output logic [1:0]  o_SR1MUX,
  output logic [1:0]  o_ADDR2MUX,
  output logic [1:0]  o_SPMUX,
  output logic [1:0]  o_VectorMUX,
  output logic [1:0]  o_ALUK,
  output logic        o_ADDR1MUX,
  output logic        o_MARMUX,
  output logic        o_TableMUX,
  output logic        o_PSRMUX,
  output logic        o_MIO_EN,
  output logic        o_R_W,
  output logic        o_Set_Priv,
  output logic        o_IllegalState
);

  logic [5:0] state;
  ctrl_word_t cw;
  logic       illegal;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RESET_STATE;
    end else if (i_Run) begin
      state <= i_AddressNextState;
    end
  end

  lc3_control_rom u_rom (
    .state   (state),
    .cw      (cw),
    .illegal (illegal)
  );

  assign o_State        = state;
  assign o_j_field      = cw.j;
  assign o_COND_bits    = cw.cond;
  assign o_IRD          = cw.ird;
  assign o_LD           = cw.ld;
  assign o_Gate         = cw.gate;
  assign o_PCMUX        = cw.pcmux;
  assign o_DRMUX        = cw.drmux;
  assign o_SR1MUX       = cw.sr1mux;
  assign o_ADDR2MUX     = cw.addr2mux;
  assign o_SPMUX        = cw.spmux;
  assign o_VectorMUX    = cw.vectormux;
  assign o_ALUK         = cw.aluk;
  assign o_ADDR1MUX     = cw.addr1mux;
  assign o_MARMUX       = cw.marmux;
  assign o_TableMUX     = cw.tablemux;
  assign o_PSRMUX       = cw.psrmux;
  assign o_MIO_EN       = cw.mio_en;
  assign o_R_W          = cw.r_w;
  assign o_Set_Priv     = cw.set_priv;
  assign o_IllegalState = illegal;

endmodule

// File: tb/tb_lc3_control_store.sv
// Bench for lc3_control_store: directed fetch/hold/illegal/reset cases, a
// closed loop through a behavioural microsequencer, then random stimulus.
module tb_lc3_control_store;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  next_addr = 6'd0;
  logic        run = 1'b1;
  logic [5:0]  o_State, o_j_field;
  logic [2:0]  o_COND_bits;
  logic        o_IRD;
  logic [10:0] o_LD;
  logic [7:0]  o_Gate;
  logic [1:0]  o_PCMUX, o_DRMUX, o_SR1MUX, o_ADDR2MUX, o_SPMUX, o_VectorMUX, o_ALUK;
  logic        o_ADDR1MUX, o_MARMUX, o_TableMUX, o_PSRMUX, o_MIO_EN, o_R_W, o_Set_Priv;
  logic        o_IllegalState;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lc3_control_store dut (
    .i_clk(clk), .i_rst(rst), .i_AddressNextState(next_addr), .i_Run(run),
    .o_State(o_State), .o_j_field(o_j_field), .o_COND_bits(o_COND_bits), .o_IRD(o_IRD),
    .o_LD(o_LD), .o_Gate(o_Gate), .o_PCMUX(o_PCMUX), .o_DRMUX(o_DRMUX), .o_SR1MUX(o_SR1MUX),
    .o_ADDR2MUX(o_ADDR2MUX), .o_SPMUX(o_SPMUX), .o_VectorMUX(o_VectorMUX), .o_ALUK(o_ALUK),
    .o_ADDR1MUX(o_ADDR1MUX), .o_MARMUX(o_MARMUX), .o_TableMUX(o_TableMUX), .o_PSRMUX(o_PSRMUX),
    .o_MIO_EN(o_MIO_EN), .o_R_W(o_R_W), .o_Set_Priv(o_Set_Priv), .o_IllegalState(o_IllegalState)
  );

  logic [50:0] act_w;
  assign act_w = {o_j_field, o_COND_bits, o_IRD, o_LD, o_Gate, o_PCMUX, o_DRMUX, o_SR1MUX,
                  o_ADDR2MUX, o_SPMUX, o_VectorMUX, o_ALUK, o_ADDR1MUX, o_MARMUX, o_TableMUX,
                  o_PSRMUX, o_MIO_EN, o_R_W, o_Set_Priv, o_IllegalState};

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Expected control word for the microstates whose content is pinned down;
  // m marks which bits are defined for that state.
  function automatic bit expect_word(input int s, output logic [50:0] e, output logic [50:0] m);
    logic [5:0] ej = 6'd0;
    logic [2:0] ec = 3'd0;
    logic ei = 1'b0, ea1 = 1'b0, emio = 1'b0, erw = 1'b0, eill = 1'b0;
    logic [10:0] eld = 11'h0;
    logic [7:0]  eg = 8'h0;
    logic [1:0]  epc = 2'd0, edr = 2'd0, esr = 2'd0, ea2 = 2'd0, ealu = 2'd0;
    logic mj = 1'b1, mall = 1'b0, mrw = 1'b0, mpcg = 1'b0, malu = 1'b0;
    bit known = 1'b1;
    case (s)
      18: begin ej = 6'd33; ec = 3'd5; eld = 11'h410; eg = 8'h80; mall = 1'b1; end
      33: begin ej = 6'd28; ec = 3'd6; end
      28: begin ej = 6'd28; ec = 3'd1; eld = 11'h200; emio = 1'b1; mrw = 1'b1; end
      30: begin ej = 6'd32; eld = 11'h100; eg = 8'h40; end
      32: begin eld = 11'h080; ei = 1'b1; mj = 1'b0; end
      1:  begin ej = 6'd18; eld = 11'h060; eg = 8'h20; esr = 2'd1; malu = 1'b1; end
      0:  begin ej = 6'd18; ec = 3'd2; end
      22: begin ej = 6'd18; eld = 11'h010; epc = 2'd2; ea2 = 2'd2; mpcg = 1'b1; end
      61, 62: begin ej = 6'd18; eill = 1'b1; end
      default: known = 1'b0;
    endcase
    e = {ej, ec, ei, eld, eg, epc, edr, esr, ea2, 2'b00, 2'b00, ealu, ea1,
         1'b0, 1'b0, 1'b0, emio, erw, 1'b0, eill};
    m = {{6{mj}}, 3'b111, 1'b1, {11{1'b1}}, {8{1'b1}}, {2{mall | mpcg}}, {2{mall | malu}},
         {2{mall | malu}}, {2{mall | mpcg}}, {2{mall}}, {2{mall}}, {2{mall | malu}},
         mall | mpcg, mall, mall, mall, 1'b1, mall | mrw, mall, 1'b1};
    return known;
  endfunction

  // Reference state: reset wins, otherwise Run loads the next address.
  int exp_state = 0;
  bit model_valid = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      exp_state = 18;
      model_valid = 1'b1;
    end else if (run && model_valid) begin
      exp_state = int'(next_addr);
    end
  end

  always @(negedge clk) begin
    logic [50:0] e, m;
    if (model_valid) begin
      chk("state_vs_model", 64'(o_State), 64'(exp_state));
      if (expect_word(exp_state, e, m))
        chk($sformatf("word_state%0d", exp_state), 64'(act_w & m), 64'(e & m));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Behavioural microsequencer: COND selects which J bit a condition may set.
  function automatic logic [5:0] useq(input logic [5:0] j, input logic [2:0] cond, input logic ird,
                                      input logic r, input logic ben, input logic psr15,
                                      input logic ir11, input logic intr, input logic acv,
                                      input logic [3:0] opcode);
    logic [5:0] a = j;
    if (ird) return {2'b00, opcode};
    case (cond)
      3'd1: a[1] = a[1] | r;
      3'd2: a[2] = a[2] | ben;
      3'd3: a[3] = a[3] | psr15;
      3'd4: a[0] = a[0] | ir11;
      3'd5: a[4] = a[4] | intr;
      3'd6: a[5] = a[5] | acv;
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    logic [5:0] walk[7];
    int exp_seq[9];
    int seen[$];
    int in28;
    logic [5:0] picks[11];
    walk = '{6'd33, 6'd28, 6'd28, 6'd30, 6'd32, 6'd1, 6'd18};
    exp_seq = '{18, 33, 28, 28, 28, 30, 32, 1, 18};
    picks = '{6'd0, 6'd1, 6'd18, 6'd22, 6'd28, 6'd30, 6'd32, 6'd33, 6'd61, 6'd62, 6'd28};

    rst = 1'b1; run = 1'b1; next_addr = 6'd30;
    tick(); tick();
    rst = 1'b0;
    chk("reset_state", 64'(o_State), 64'd18);
    chk("reset_j", 64'(o_j_field), 64'd33);
    chk("reset_cond", 64'(o_COND_bits), 64'd5);
    chk("reset_ld_mar", 64'(o_LD[10]), 64'd1);
    chk("reset_illegal", 64'(o_IllegalState), 64'd0);

    foreach (walk[i]) begin
      next_addr = walk[i];
      tick();
      chk($sformatf("walk_%0d", i), 64'(o_State), 64'(walk[i]));
      if (walk[i] == 6'd28) begin
        chk("walk28_mio", 64'(o_MIO_EN), 64'd1);
        chk("walk28_rw", 64'(o_R_W), 64'd0);
      end
      if (walk[i] == 6'd32) chk("walk32_ird_ben", 64'({o_IRD, o_LD[7]}), 64'h3);
      if (walk[i] == 6'd1) chk("walk1_reg_cc_alu", 64'({o_LD[6], o_LD[5], o_Gate[5]}), 64'h7);
    end

    next_addr = 6'd33; tick();
    next_addr = 6'd28; tick();
    run = 1'b0; next_addr = 6'd30;
    repeat (3) begin
      tick();
      chk("hold_state", 64'(o_State), 64'd28);
      chk("hold_mio", 64'(o_MIO_EN), 64'd1);
    end
    run = 1'b1; tick();
    chk("resume_state", 64'(o_State), 64'd30);

    next_addr = 6'd61; tick();
    chk("illegal_flag", 64'(o_IllegalState), 64'd1);
    chk("illegal_ld_gate", 64'({o_LD, o_Gate}), 64'd0);
    chk("illegal_j_cond", 64'({o_j_field, o_COND_bits}), 64'({6'd18, 3'd0}));
    next_addr = 6'd18; tick();
    chk("illegal_recover", 64'(o_State), 64'd18);

    next_addr = 6'd33; tick();
    next_addr = 6'd28; tick();
    rst = 1'b1; next_addr = 6'd30; tick();
    rst = 1'b0;
    chk("midop_reset", 64'(o_State), 64'd18);

    in28 = 0;
    for (int c = 0; c < 9; c++) begin
      seen.push_back(int'(o_State));
      in28 = (o_State == 6'd28) ? in28 + 1 : 0;
      next_addr = useq(o_j_field, o_COND_bits, o_IRD, in28 >= 3, 1'b0, 1'b0, 1'b0,
                       1'b0, 1'b0, 4'b0001);
      tick();
    end
    foreach (exp_seq[i])
      chk($sformatf("loop_step%0d", i), 64'(seen[i]), 64'(exp_seq[i]));

    repeat (800) begin
      rst = ($urandom_range(0, 49) == 0);
      run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) next_addr = picks[$urandom_range(0, 10)];
      else next_addr = 6'($urandom_range(0, 63));
      tick();
    end
    rst = 1'b0; run = 1'b1; next_addr = 6'd18;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_control_store.md
# lc3_control_store

Control store and state register for the LC-3 microcoded control unit. Holds the current microstate, registering the 6-bit next-state address produced by `microsequencer` each cycle. Decodes the current state through a microcode ROM into the J/COND/IRD fields that feed back to `microsequencer` and the datapath control signals that drive the LC-3 datapath.

## Interface
Parameters:
- `RESET_STATE`, default 18: microstate loaded on reset (fetch entry).

Ports:
- `i_clk`  in  1  system clock; all state changes on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_AddressNextState`  in  6  next microstate from `microsequencer`.
- `i_Run`  in  1  1 = advance state each cycle; 0 = hold current state.
- `o_State`  out  6  current microstate (register output).
- `o_j_field`  out  6  J field of current microinstruction.
- `o_COND_bits`  out  3  COND field: 000 none, 001 R, 010 BEN, 011 PSR[15], 100 IR[11], 101 INT, 110 ACV.
- `o_IRD`  out  1  IRD field.
- `o_LD`  out  11  load enables {MAR, MDR, IR, BEN, REG, CC, PC, Priv, SavedSSP, SavedUSP, Vector}, MSB first.
- `o_Gate`  out  8  gate enables {PC, MDR, ALU, MARMUX, Vector, PCm1, PSR, SP}, MSB first.
- `o_PCMUX`, `o_DRMUX`, `o_SR1MUX`, `o_ADDR2MUX`, `o_SPMUX`, `o_VectorMUX`, `o_ALUK`  out  2 each  mux selects / ALU op.
- `o_ADDR1MUX`, `o_MARMUX`, `o_TableMUX`, `o_PSRMUX`, `o_MIO_EN`, `o_R_W`, `o_Set_Priv`  out  1 each.
- `o_IllegalState`  out  1  current state has no defined microinstruction.

## Operation
- State register `state[5:0]`: on `i_rst`, load `RESET_STATE`. Otherwise if `i_Run`, load `i_AddressNextState`; else hold.
- All other outputs are combinational from `state` only (Moore). No output depends combinationally on `i_AddressNextState`.
- ROM content: the standard LC-3 microprogram, states 0–63. Required entries include:
  - State 18: LD.MAR, LD.PC, Gate.PC, PCMUX=00; COND=101, J=33.
  - State 33: COND=110, J=28.
  - State 28: LD.MDR, MIO.EN=1, R.W=0; COND=001, J=28.
  - State 30: LD.IR, Gate.MDR; COND=000, J=32.
  - State 32: LD.BEN, IRD=1, J=don't-care.
  - State 1 (ADD): LD.REG, LD.CC, Gate.ALU, ALUK=00, DRMUX=00, SR1MUX=01; J=18.
  - State 0 (BR): COND=010, J=18.
  - State 22: LD.PC, PCMUX=10, ADDR1MUX=0, ADDR2MUX=10; J=18.
- Undefined states: all load/gate enables 0, MIO.EN=0, J=18, COND=000, IRD=0, `o_IllegalState`=1. The machine therefore returns to fetch on the next advancing cycle with no datapath side effects.
- Defined states: `o_IllegalState`=0.

## Timing
- Reset: after the first rising edge with `i_rst`=1, `o_State`=18 and outputs are state 18's word: J=33, COND=101, IRD=0, LD.MAR=LD.PC=Gate.PC=1, everything else 0. Reset overrides `i_Run` and takes effect mid-instruction, including mid-memory-wait in state 28.
- Latency: `i_AddressNextState` sampled at edge N appears on `o_State` after edge N; control fields are valid in the same cycle. One microstate per clock. The feedback loop through `microsequencer` is fully combinational between edges.
- Self-loop (state 28 with R=0) is just `i_AddressNextState`=28 being reloaded; no special handling.
- `i_Run`=0: the state and every output remain constant for as long as it stays low. On the rising edge after `i_Run` returns high, the then-current `i_AddressNextState` is loaded.

## Structure
- Shared package `lc3_ctrl_pkg`:
  - COND encodings.
  - Named state constants (`ST_FETCH`=18, `ST_ACV`=33, `ST_READ`=28, `ST_LDIR`=30, `ST_DECODE`=32, …).
  - Microinstruction field widths and bit positions in a packed control word.
- Sub-module `lc3_control_rom`: purely combinational `case` on state, returning the packed control word plus illegal flag.
- `lc3_control_store`: state register plus field unpacking.

## Test plan
- Reset: assert `i_rst` for 2 cycles with `i_Run`=1 → `o_State`=18, J=33, COND=101, LD.MAR=1, `o_IllegalState`=0.
- Fetch walk: drive `i_AddressNextState` 33, 28, 28, 30, 32, 1, 18 on successive cycles → `o_State` follows one cycle later. At 28: MIO.EN=1, R.W=0. At 32: IRD=1, LD.BEN=1. At 1: LD.REG=LD.CC=Gate.ALU=1.
- Hold: in state 28, drop `i_Run` for 3 cycles while driving 30 → `o_State` stays 28. Raise `i_Run` → `o_State`=30 next cycle.
- Illegal: drive an undefined state (e.g. 61) → `o_IllegalState`=1, all LD/Gate=0, J=18, COND=000. Next cycle, driving 18 → state 18.
- Mid-op reset: in state 28 with `i_Run`=1, assert `i_rst` for 1 cycle while driving 30 → `o_State`=18, not 30.
- Closed loop with `microsequencer`: instance both; ADD opcode, INT=0, ACV=0, R high after 2 cycles → state sequence 18, 33, 28, 28, 28, 30, 32, 1, 18.
